// File: rtl/open_list_search.sv
// Open-list store with a multi-lane associative search for an (x,y) key; optional delete via OPEN_LIST_DELETE_EN.
// Latency: hit in chunk k -> done k+2 cycles after start; miss -> 1+ceil(count/LANES) cycles (min 2).
// Backpressure: start ignored while busy; list ops rejected with an op_err pulse outside IDLE or when start is high.
module open_list_search #(
    parameter int COORD_W = 8,
    parameter int DEPTH   = 400,
    parameter int LANES   = 4,
    localparam int IDX_W  = $clog2(DEPTH + 1)
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               ins_en,
    input  logic [COORD_W-1:0] ins_x,
    input  logic [COORD_W-1:0] ins_y,
    input  logic               del_en,
    input  logic [IDX_W-1:0]   del_idx,
    input  logic               start,
    input  logic [COORD_W-1:0] check_x,
    input  logic [COORD_W-1:0] check_y,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic [IDX_W-1:0]   found_idx,
    output logic [IDX_W-1:0]   count,
    output logic               full,
    output logic               empty,
    output logic               op_err
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t             state, state_nxt;
    logic [COORD_W-1:0] openx [0:DEPTH-1];
    logic [COORD_W-1:0] openy [0:DEPTH-1];
    logic [COORD_W-1:0] key_x, key_y;
    logic [IDX_W-1:0]   base;
    logic               hit, last_chunk;
    logic [IDX_W-1:0]   hit_idx;
    logic               ins_ok, del_ok, op_rej;

    assign busy  = (state != IDLE);
    assign done  = (state == DONE);
    assign full  = (count == IDX_W'(DEPTH));
    assign empty = (count == '0);

    // Compare one chunk of lanes; walk lanes high-to-low so the lowest match wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            logic [IDX_W:0] li;
            li = {1'b0, base} + (IDX_W + 1)'(i);
            if (li < {1'b0, count} && li < (IDX_W + 1)'(DEPTH) &&
                openx[li[IDX_W-1:0]] == key_x && openy[li[IDX_W-1:0]] == key_y) begin
                hit     = 1'b1;
                hit_idx = li[IDX_W-1:0];
            end
        end
        last_chunk = ({1'b0, base} + (IDX_W + 1)'(LANES)) >= {1'b0, count};
    end

    // Decide whether a list operation this cycle is performed or rejected.
    always_comb begin
        ins_ok = 1'b0;
        del_ok = 1'b0;
        op_rej = 1'b0;
`ifdef OPEN_LIST_DELETE_EN
        if (ins_en || del_en) begin
            if (state != IDLE || start || (ins_en && del_en)) op_rej = 1'b1;
            else if (ins_en) begin
                if (full) op_rej = 1'b1;
                else      ins_ok = 1'b1;
            end else begin
                if (del_idx >= count) op_rej = 1'b1;
                else                  del_ok = 1'b1;
            end
        end
`else
        if (ins_en) begin
            if (state != IDLE || start || full) op_rej = 1'b1;
            else                                ins_ok = 1'b1;
        end
`endif
    end

`ifndef OPEN_LIST_DELETE_EN
    // Delete ports exist for interface compatibility but carry no function in this build.
    logic unused_del;
    assign unused_del = ^{del_en, del_idx};
`endif

    // Search FSM next-state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    if (hit || last_chunk) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register; a reset mid-search simply drops back to IDLE, so no done pulse follows.
    always_ff @(posedge Clk) begin
        if (!Reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Search datapath: key capture, chunk pointer and result registers.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            base      <= '0;
            found     <= 1'b0;
            found_idx <= '0;
            key_x     <= '0;
            key_y     <= '0;
        end else if (state == IDLE && start) begin
            key_x     <= check_x;
            key_y     <= check_y;
            base      <= '0;
            found     <= 1'b0;
            found_idx <= '0;
        end else if (state == SCAN) begin
            if (hit) begin
                found     <= 1'b1;
                found_idx <= hit_idx;
            end else if (last_chunk) begin
                found     <= 1'b0;
                found_idx <= '0;
            end else begin
                base <= base + IDX_W'(LANES);
            end
        end
    end

    // Occupancy counter and rejection pulse.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            count  <= '0;
            op_err <= 1'b0;
        end else begin
            op_err <= op_rej;
            if (ins_ok)      count <= count + IDX_W'(1);
            else if (del_ok) count <= count - IDX_W'(1);
        end
    end

    // Entry storage; not reset, since only indices below count are ever considered valid.
    always_ff @(posedge Clk) begin
        if (Reset && ins_ok) begin
            openx[count] <= ins_x;
            openy[count] <= ins_y;
        end else if (Reset && del_ok) begin
            openx[del_idx] <= openx[count - IDX_W'(1)];
            openy[del_idx] <= openy[count - IDX_W'(1)];
        end
    end

endmodule

// File: tb/tb_open_list_search.sv
// Randomized self-checking bench for open_list_search against a queue-based reference list.
// Latency is checked as the cycle offset of done relative to the accepted start.
// Exercises rejected ops, busy-time start/insert, full list and reset abort.
module tb_open_list_search;
    localparam int CW    = 8;
    localparam int DEPTH = 400;
    localparam int LANES = 4;
    localparam int IW    = $clog2(DEPTH + 1);

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic          ins_en = 1'b0, del_en = 1'b0, start = 1'b0;
    logic [CW-1:0] ins_x = '0, ins_y = '0, check_x = '0, check_y = '0;
    logic [IW-1:0] del_idx = '0;
    logic          busy, done, found, full, empty, op_err;
    logic [IW-1:0] found_idx, count;

    int checks = 0;
    int errors = 0;
    int mx[$];
    int my[$];

    open_list_search #(.COORD_W(CW), .DEPTH(DEPTH), .LANES(LANES)) dut (
        .Clk(Clk), .Reset(Reset),
        .ins_en(ins_en), .ins_x(ins_x), .ins_y(ins_y),
        .del_en(del_en), .del_idx(del_idx),
        .start(start), .check_x(check_x), .check_y(check_y),
        .busy(busy), .done(done), .found(found), .found_idx(found_idx),
        .count(count), .full(full), .empty(empty), .op_err(op_err)
    );

    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset;
        Reset = 1'b0;
        tick;
        Reset = 1'b1;
        mx.delete();
        my.delete();
    endtask

    // One-cycle list operation; reference list updated from the behavioural rules.
    task automatic list_op(input bit ie, input bit de, input int x, input int y,
                           input int idx, input string tag);
        bit exp_err;
        ins_en = ie; del_en = de; ins_x = CW'(x); ins_y = CW'(y); del_idx = IW'(idx);
        exp_err = 1'b0;
`ifdef OPEN_LIST_DELETE_EN
        if (ie && de) exp_err = 1'b1;
        else if (ie) begin
            if (mx.size() == DEPTH) exp_err = 1'b1;
            else begin mx.push_back(x); my.push_back(y); end
        end else if (de) begin
            if (idx >= mx.size()) exp_err = 1'b1;
            else begin
                mx[idx] = mx[mx.size()-1];
                my[idx] = my[my.size()-1];
                void'(mx.pop_back());
                void'(my.pop_back());
            end
        end
`else
        if (ie) begin
            if (mx.size() == DEPTH) exp_err = 1'b1;
            else begin mx.push_back(x); my.push_back(y); end
        end
`endif
        tick;
        ins_en = 1'b0; del_en = 1'b0;
        check_val({tag, "_op_err"}, int'(op_err), int'(exp_err));
        check_val({tag, "_count"}, int'(count), mx.size());
    endtask

    // Search with noise: random start pulses while busy, optional insert attempt during SCAN.
    task automatic search(input int kx, input int ky, input bit inject, input string tag);
        int exp_idx, exp_lat, n, sz;
        bit got;
        sz = mx.size();
        exp_idx = -1;
        for (int i = 0; i < sz; i++)
            if (mx[i] == kx && my[i] == ky) begin exp_idx = i; break; end
        if (exp_idx >= 0) exp_lat = 2 + exp_idx / LANES;
        else              exp_lat = (sz == 0) ? 2 : 1 + (sz + LANES - 1) / LANES;
        start = 1'b1; check_x = CW'(kx); check_y = CW'(ky);
        tick;
        start = 1'b0;
        n = 1; got = 1'b0;
        while (n <= 200 && !got) begin
            if (done) got = 1'b1;
            else begin
                if (n == 1) check_val({tag, "_busy"}, int'(busy), 1);
                start = 1'($urandom % 2); check_x = CW'($urandom); check_y = CW'($urandom);
                if (inject && n == 1) ins_en = 1'b1;
                tick;
                if (inject && n == 1) begin
                    ins_en = 1'b0;
                    check_val({tag, "_busy_ins_err"}, int'(op_err), 1);
                    check_val({tag, "_busy_ins_count"}, int'(count), sz);
                end
                n++;
            end
        end
        start = 1'b0;
        check_val({tag, "_done_cycle"}, got ? n : -1, exp_lat);
        check_val({tag, "_found"}, int'(found), (exp_idx >= 0) ? 1 : 0);
        check_val({tag, "_found_idx"}, int'(found_idx), (exp_idx >= 0) ? exp_idx : 0);
        tick;
        check_val({tag, "_done_pulse"}, int'(done), 0);
        check_val({tag, "_idle"}, int'(busy), 0);
        check_val({tag, "_found_hold"}, int'(found), (exp_idx >= 0) ? 1 : 0);
    endtask

    initial begin
        int r, dsum;
        Reset = 1'b0;
        tick; tick;
        Reset = 1'b1;

        // Reset state
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_done", int'(done), 0);
        check_val("rst_found", int'(found), 0);
        check_val("rst_found_idx", int'(found_idx), 0);
        check_val("rst_op_err", int'(op_err), 0);
        check_val("rst_count", int'(count), 0);
        check_val("rst_empty", int'(empty), 1);
        check_val("rst_full", int'(full), 0);

        // Empty list search
        search(3, 3, 1'b0, "empty_search");

        // Six-entry list: hit in second chunk, miss, busy-time insert
        for (int i = 1; i <= 6; i++) list_op(1'b1, 1'b0, i, i, 0, "fill6");
        search(6, 6, 1'b1, "hit6");
        search(9, 9, 1'b0, "miss9");
        list_op(1'b1, 1'b1, 8, 8, 0, "ins_del_same");
        search(6, 6, 1'b0, "hit6_after");

        // Duplicates resolve to the lowest index
        do_reset;
        list_op(1'b1, 1'b0, 1, 1, 0, "dup");
        list_op(1'b1, 1'b0, 2, 2, 0, "dup");
        list_op(1'b1, 1'b0, 7, 7, 0, "dup");
        list_op(1'b1, 1'b0, 7, 7, 0, "dup");
        search(7, 7, 1'b0, "dup7");

        // Delete behaviour (ignored when the feature is compiled out)
        do_reset;
        for (int i = 1; i <= 3; i++) list_op(1'b1, 1'b0, i, i, 0, "del3");
        list_op(1'b0, 1'b1, 0, 0, 0, "del_idx0");
        search(3, 3, 1'b0, "after_del");
        list_op(1'b0, 1'b1, 0, 0, 5, "del_idx5");

        // Randomized mix
        do_reset;
        for (int it = 0; it < 500; it++) begin
            r = $urandom % 20;
            if (r < 11)      list_op(1'b1, 1'b0, $urandom % 6, $urandom % 6, 0, "rnd_ins");
            else if (r < 15) list_op(1'b0, 1'b1, 0, 0, $urandom % (mx.size() + 3), "rnd_del");
            else if (r < 16) list_op(1'b1, 1'b1, $urandom % 6, $urandom % 6,
                                     $urandom % (mx.size() + 1), "rnd_both");
            else             search($urandom % 7, $urandom % 7, 1'($urandom % 2), "rnd_search");
        end

        // Full list and overflow attempt
        do_reset;
        for (int i = 0; i < DEPTH; i++) list_op(1'b1, 1'b0, i % 200, i / 200, 0, "full_fill");
        check_val("full_flag", int'(full), 1);
        check_val("full_empty", int'(empty), 0);
        list_op(1'b1, 1'b0, 1, 1, 0, "overflow");
        search(199, 1, 1'b0, "full_last");
        search(250, 250, 1'b0, "full_miss");

        // Reset in the middle of a long scan
        start = 1'b1; check_x = 8'd250; check_y = 8'd250;
        tick;
        start = 1'b0;
        tick; tick;
        Reset = 1'b0;
        tick;
        Reset = 1'b1;
        mx.delete(); my.delete();
        check_val("abort_busy", int'(busy), 0);
        check_val("abort_count", int'(count), 0);
        check_val("abort_done", int'(done), 0);
        dsum = 0;
        for (int i = 0; i < 8; i++) begin
            tick;
            dsum += int'(done);
        end
        check_val("abort_no_done", dsum, 0);
        search(1, 1, 1'b0, "post_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/open_list_search.md
OPEN_LIST_SEARCH -- requirements
Module: open_list_search

Interface
REQ-001 SHALL have parameter COORD_W, default 8, coordinate width in bits.
REQ-002 SHALL have parameter DEPTH, default 400, open-list capacity in entries.
REQ-003 SHALL have parameter LANES, default 4, entries compared per cycle (1..DEPTH).
REQ-004 SHALL have derived localparam IDX_W = clog2(DEPTH+1), width of index and count.
REQ-005 Clk  input  1  sole clock, rising edge.
REQ-006 Reset  input  1  one clock; reset is synchronous and active-low.
REQ-007 ins_en  input  1  append (ins_x, ins_y) at tail.
REQ-008 ins_x, ins_y  input  COORD_W each  entry to append.
REQ-009 del_en  input  1  remove entry del_idx.
REQ-010 del_idx  input  IDX_W  index to remove.
REQ-011 start  input  1  begin search for (check_x, check_y), sampled in IDLE only.
REQ-012 check_x, check_y  input  COORD_W each  search key, captured on accepted start.
REQ-013 busy  output  1  high in SCAN and DONE.
REQ-014 done  output  1  one-cycle pulse, search complete.
REQ-015 found  output  1  key present; valid from done until next accepted start.
REQ-016 found_idx  output  IDX_W  lowest matching index; 0 when not found.
REQ-017 count  output  IDX_W  valid entries; full = (count==DEPTH), empty = (count==0) outputs, 1 bit each.
REQ-018 op_err  output  1  one-cycle pulse, list operation rejected.

Function
REQ-019 SHALL store entries in internal arrays openx/openy[0:DEPTH-1]; only indices < count are valid.
REQ-020 States IDLE, SCAN, DONE; accepted start in IDLE: latch key, base=0, found=0, go to SCAN.
REQ-021 SCAN: compare lanes base..base+LANES-1, lanes with index >= count or >= DEPTH masked.
REQ-022 SCAN, any lane matches (x and y equal): found=1, found_idx=lowest matching index, go to DONE.
REQ-023 SCAN, no match and base+LANES >= count: found=0, found_idx=0, go to DONE; else base += LANES.
REQ-024 DONE: done=1 for exactly that cycle, then IDLE.
REQ-025 Latency: start at cycle T, match in chunk k (k = idx/LANES) -> done at T+2+k; miss -> done at T+1+ceil(count/LANES), minimum T+2 (count=0).
REQ-026 start while busy SHALL be ignored, no error.
REQ-027 ins_en/del_en SHALL be accepted only in IDLE and without start the same cycle; otherwise op_err pulses and list unchanged.
REQ-028 Insert: openx/openy[count] <= ins_x/ins_y, count+1; when full -> op_err, no change.
REQ-029 ins_en and del_en same cycle -> op_err, neither performed.
REQ-030 Rejected operations SHALL not disturb search state or outputs.
REQ-031 count SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-032 Reset low at a rising edge: state IDLE, count=0, busy=0, done=0, found=0, found_idx=0, op_err=0, base=0.
REQ-033 Reset mid-search SHALL abort; no done pulse issued; storage contents need not be cleared.

Configuration
REQ-034 Macro OPEN_LIST_DELETE_EN defined: del_en accepted in IDLE; del_idx < count -> entry[del_idx] <= entry[count-1], count-1; del_idx >= count -> op_err.
REQ-035 Macro OPEN_LIST_DELETE_EN undefined: del_en, del_idx ports present but ignored (no op_err, no change, REQ-029 conflict does not apply); list shrinks only via Reset.

Verification
REQ-036 LANES=4: insert (1,1),(2,2),(3,3),(4,4),(5,5),(6,6); start key (6,6) at T -> done at T+3, found=1, found_idx=5.
REQ-037 Same list, key (9,9) at T -> done at T+3, found=0, found_idx=0; count=0 search -> done at T+2, found=0.
REQ-038 Duplicates (7,7) at idx 2 and 3 -> found_idx=2; DEPTH inserts then one more -> op_err=1, count=DEPTH.
REQ-039 ins_en during busy, and ins_en+del_en together in IDLE -> op_err pulse each, count unchanged, search result unaffected.
REQ-040 OPEN_LIST_DELETE_EN: list (1,1),(2,2),(3,3), delete idx 0 -> count=2, search (3,3) -> found_idx=0; delete idx 5 -> op_err.
REQ-041 Reset low during SCAN -> next cycle busy=0, count=0, no done pulse.
